scr1_ahb_dmem_slave: RTL and testbench

Synthesizable AHB-Lite responder for the SCR1 data-memory port. It terminates the core's dmem_h* initiator signals in on-chip word-organised storage, for example the LeNet weight/feature buffer. Features: configurable fixed wait states, byte-lane writes, and a two-cycle ERROR response for illegal transfers. Point-to-point: no HSEL and no HREADY input; the slave's own hready qualifies each address phase.

---
 rtl/scr1_ahb_dmem_slave_pkg.sv | 34 +++
 rtl/scr1_ahb_dmem_slave_if.sv | 24 ++
 rtl/scr1_ahb_slave_ram.sv | 40 ++++
 rtl/scr1_ahb_dmem_slave.sv | 123 ++++++++++++
 tb/tb_scr1_ahb_dmem_slave.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_ahb_dmem_slave_pkg.sv
// Shared AHB-Lite constants, responder state type and byte-lane helper
// for the SCR1 data-memory responder.
package scr1_ahb_dmem_slave_pkg;

    localparam int SCR1_AHB_WIDTH = 32;

    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SCR1_HSIZE_8BIT  = 3'd0;
    localparam logic [2:0] SCR1_HSIZE_16BIT = 3'd1;
    localparam logic [2:0] SCR1_HSIZE_32BIT = 3'd2;

    typedef enum logic [2:0] {
        SCR1_SLV_IDLE,
        SCR1_SLV_WAIT,
        SCR1_SLV_DATA,
        SCR1_SLV_ERR1,
        SCR1_SLV_ERR2
    } type_scr1_ahb_slv_state_e;

    // Little-endian byte lanes touched by a transfer of the given size/offset
    function automatic logic [3:0] scr1_ahb_byte_en(input logic [2:0] hsize,
                                                    input logic [1:0] addr);
        case (hsize)
            SCR1_HSIZE_8BIT:  return 4'b0001 << addr;
            SCR1_HSIZE_16BIT: return addr[1] ? 4'b1100 : 4'b0011;
            default:          return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/scr1_ahb_dmem_slave_if.sv
// AHB-Lite point-to-point bus between the SCR1 dmem initiator and a responder.
interface scr1_ahb_dmem_slave_if;
    import scr1_ahb_dmem_slave_pkg::*;

    logic [2:0]                hsize;
    logic [1:0]                htrans;
    logic [SCR1_AHB_WIDTH-1:0] haddr;
    logic                      hwrite;
    logic [SCR1_AHB_WIDTH-1:0] hwdata;
    logic                      hready;
    logic [SCR1_AHB_WIDTH-1:0] hrdata;
    logic                      hresp;

    modport master (
        output hsize, htrans, haddr, hwrite, hwdata,
        input  hready, hrdata, hresp
    );

    modport slave (
        input  hsize, htrans, haddr, hwrite, hwdata,
        output hready, hrdata, hresp
    );

endinterface

// File: rtl/scr1_ahb_slave_ram.sv
// Word-organised storage with a byte-enable write port and a registered
// read port; a write landing on the word being read in the same cycle is
// merged into the read result so back-to-back write/read sees new data.
module scr1_ahb_slave_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wbe,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] fwd;

    // Byte-lane write
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Read word with same-cycle write bytes forwarded
    always_comb begin
        fwd = mem[raddr];
        for (int b = 0; b < 4; b++) begin
            if (we && wbe[b] && (waddr == raddr)) fwd[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (re) rdata <= fwd;
    end

endmodule

// File: rtl/scr1_ahb_dmem_slave.sv
// AHB-Lite responder for the SCR1 data-memory port: fixed wait states,
// byte-lane writes, two-cycle ERROR for misaligned/out-of-region transfers.
module scr1_ahb_dmem_slave #(
    parameter int          SCR1_MEM_POWER_SIZE = 16,
    parameter int          WAIT_STATES         = 0,
    parameter logic [31:0] BASE_ADDR           = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scr1_ahb_dmem_slave_if.slave  bus
);
    import scr1_ahb_dmem_slave_pkg::*;

    localparam int         P       = SCR1_MEM_POWER_SIZE;
    localparam int         AW      = P - 2;
    localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    type_scr1_ahb_slv_state_e state;
    logic [2:0]               wait_cnt;
    logic [AW-1:0]            dp_addr;
    logic [3:0]               dp_be;
    logic                     dp_write;

    logic                     accept;
    logic                     illegal;
    logic                     ram_we;
    logic                     ram_re;
    logic [AW-1:0]            ram_raddr;
    logic [31:0]              ram_rdata;
    logic                     unused_htrans0;

    assign unused_htrans0 = bus.htrans[0];

    // Address-phase acceptance and legality decode
    always_comb begin
        accept  = bus.hready & bus.htrans[1];
        illegal = 1'b0;
        if (bus.hsize > SCR1_HSIZE_32BIT)                            illegal = 1'b1;
        if ((bus.hsize == SCR1_HSIZE_16BIT) && bus.haddr[0])         illegal = 1'b1;
        if ((bus.hsize == SCR1_HSIZE_32BIT) && (bus.haddr[1:0] != 2'b00)) illegal = 1'b1;
        if (bus.haddr[SCR1_AHB_WIDTH-1:P] != BASE_ADDR[SCR1_AHB_WIDTH-1:P]) illegal = 1'b1;
    end

    // Transfer FSM with registered hready/hresp and latched address phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCR1_SLV_IDLE;
            wait_cnt   <= 3'd0;
            bus.hready <= 1'b1;
            bus.hresp  <= 1'b0;
            dp_addr    <= '0;
            dp_be      <= 4'b0000;
            dp_write   <= 1'b0;
        end else begin
            case (state)
                SCR1_SLV_WAIT: begin
                    if (wait_cnt == WS_LAST) begin
                        state      <= SCR1_SLV_DATA;
                        wait_cnt   <= 3'd0;
                        bus.hready <= 1'b1;
                    end else begin
                        wait_cnt   <= wait_cnt + 3'd1;
                    end
                end
                SCR1_SLV_ERR1: begin
                    state      <= SCR1_SLV_ERR2;
                    bus.hready <= 1'b1;
                    bus.hresp  <= 1'b1;
                end
                // IDLE, DATA and ERR2 all present hready=1, so a new
                // address phase may be taken here (back-to-back chaining)
                default: begin
                    if (accept) begin
                        dp_addr  <= bus.haddr[P-1:2];
                        dp_be    <= scr1_ahb_byte_en(bus.hsize, bus.haddr[1:0]);
                        dp_write <= bus.hwrite & ~illegal;
                    end
                    if (accept && illegal) begin
                        state      <= SCR1_SLV_ERR1;
                        bus.hready <= 1'b0;
                        bus.hresp  <= 1'b1;
                    end else if (accept && (WAIT_STATES > 0)) begin
                        state      <= SCR1_SLV_WAIT;
                        wait_cnt   <= 3'd0;
                        bus.hready <= 1'b0;
                        bus.hresp  <= 1'b0;
                    end else if (accept) begin
                        state      <= SCR1_SLV_DATA;
                        bus.hready <= 1'b1;
                        bus.hresp  <= 1'b0;
                    end else begin
                        state      <= SCR1_SLV_IDLE;
                        bus.hready <= 1'b1;
                        bus.hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Writes commit in the data cycle; reads are fetched so the word is
    // registered exactly when the data cycle begins
    always_comb begin
        ram_we    = (state == SCR1_SLV_DATA) && dp_write;
        ram_re    = ((WAIT_STATES == 0) && accept && !illegal && !bus.hwrite) ||
                    ((state == SCR1_SLV_WAIT) && (wait_cnt == WS_LAST) && !dp_write);
        ram_raddr = (state == SCR1_SLV_WAIT) ? dp_addr : bus.haddr[P-1:2];
    end

    assign bus.hrdata = ((state == SCR1_SLV_DATA) && !dp_write) ? ram_rdata : '0;

    scr1_ahb_slave_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wbe   (dp_be),
        .waddr (dp_addr),
        .wdata (bus.hwdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_scr1_ahb_dmem_slave.sv
// Bench for scr1_ahb_dmem_slave: three instances (0, 3 and 2 wait states)
// share one stimulus bus, selected by sel; a transfer-level model predicts
// hready/hresp/hrdata every cycle and directed reads pin literal values.
module tb_scr1_ahb_dmem_slave;
    import scr1_ahb_dmem_slave_pkg::*;

    typedef struct {
        logic [1:0]  trans;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } log_t;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel = 0;
    logic [1:0]  htrans_d = 2'b00;
    logic [2:0]  hsize_d  = 3'd0;
    logic [31:0] haddr_d  = 32'h0;
    logic        hwrite_d = 1'b0;
    logic [31:0] hwdata_d = 32'h0;

    logic [2:0]  hr_a;
    logic [2:0]  rs_a;
    logic [31:0] rd_a [3];
    logic        hready_s, hresp_s;
    logic [31:0] hrdata_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        scr1_ahb_dmem_slave_if b ();
        assign b.htrans = (sel == k) ? htrans_d : SCR1_HTRANS_IDLE;
        assign b.hsize  = hsize_d;
        assign b.haddr  = haddr_d;
        assign b.hwrite = hwrite_d;
        assign b.hwdata = hwdata_d;
        assign hr_a[k]  = b.hready;
        assign rs_a[k]  = b.hresp;
        assign rd_a[k]  = b.hrdata;
        scr1_ahb_dmem_slave #(
            .SCR1_MEM_POWER_SIZE (16),
            .WAIT_STATES         (ws_of(k)),
            .BASE_ADDR           (32'h0001_0000)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (b)
        );
    end

    assign hready_s = hr_a[sel];
    assign hresp_s  = rs_a[sel];
    assign hrdata_s = rd_a[sel];

    // ---------------- transfer-level model ----------------
    logic [31:0] mem [int];
    bit          model_on = 1'b0;
    bit          pv = 1'b0, p_ok, p_wr;
    int          p_left, p_eph;
    logic [31:0] p_addr;
    logic [2:0]  p_size;
    logic        m_rdy = 1'b1, m_resp = 1'b0;
    logic [31:0] m_rd = 32'h0;
    bit          m_known = 1'b1;
    bit          rdy_now;

    function automatic int key_of(input int s, input logic [31:0] a);
        return s * 65536 + int'((a - 32'h0001_0000) >> 2);
    endfunction

    function automatic bit legal(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b0;
        if (sz == 3'd1 && (a % 2) != 0) return 1'b0;
        if (sz == 3'd2 && (a % 4) != 0) return 1'b0;
        return (a >= 32'h0001_0000) && (a < 32'h0002_0000);
    endfunction

    function automatic bit lane_on(input logic [2:0] sz, input logic [31:0] a, input int b);
        if (sz == 3'd2) return 1'b1;
        if (sz == 3'd1) return (b / 2) == int'((a % 4) / 2);
        return b == int'(a % 4);
    endfunction

    function automatic logic [31:0] mdl_word(input int s, input logic [31:0] a);
        int k;
        k = key_of(s, a);
        return mem.exists(k) ? mem[k] : 32'hxxxx_xxxx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv = 1'b0; m_rdy = 1'b1; m_resp = 1'b0; m_rd = 32'h0; m_known = 1'b1;
        end else begin
            rdy_now = m_rdy;
            if (pv) begin
                if (!p_ok) begin
                    if (p_eph == 1) p_eph = 2; else pv = 1'b0;
                end else if (p_left == 0) begin
                    if (p_wr) begin
                        int k; logic [31:0] w;
                        k = key_of(sel, p_addr);
                        w = mem.exists(k) ? mem[k] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (lane_on(p_size, p_addr, b)) w[8*b +: 8] = hwdata_d[8*b +: 8];
                        mem[k] = w;
                    end
                    pv = 1'b0;
                end else begin
                    p_left--;
                end
            end
            if (rdy_now && htrans_d[1]) begin
                pv = 1'b1; p_ok = legal(hsize_d, haddr_d); p_wr = hwrite_d;
                p_addr = haddr_d; p_size = hsize_d; p_left = ws_of(sel); p_eph = 1;
            end
            m_rdy = 1'b1; m_resp = 1'b0; m_rd = 32'h0; m_known = 1'b1;
            if (pv) begin
                if (!p_ok) begin
                    m_resp = 1'b1; m_rdy = (p_eph == 2);
                end else if (p_left > 0) begin
                    m_rdy = 1'b0;
                end else if (!p_wr) begin
                    int k;
                    k = key_of(sel, p_addr);
                    if (mem.exists(k)) m_rd = mem[k]; else m_known = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && model_on) begin
            checks++;
            if (hready_s !== m_rdy || hresp_s !== m_resp || (m_known && hrdata_s !== m_rd)) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t sel=%0d: got hready=%b hresp=%b hrdata=%h, expected hready=%b hresp=%b hrdata=%h",
                         $time, sel, hready_s, hresp_s, hrdata_s, m_rdy, m_resp, m_rd);
            end
        end
    end

    // ---------------- driver ----------------
    xfer_t seq[$];
    log_t  lg[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] tr, input logic [2:0] sz, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.trans = tr; x.size = sz; x.wr = wr; x.addr = a; x.wdata = d;
        seq.push_back(x);
    endtask

    task automatic drive(input bit cv, input xfer_t c, input bit dv, input xfer_t d);
        htrans_d = cv ? c.trans : SCR1_HTRANS_IDLE;
        hsize_d  = cv ? c.size  : 3'd0;
        haddr_d  = cv ? c.addr  : 32'h0;
        hwrite_d = cv ? c.wr    : 1'b0;
        hwdata_d = dv ? d.wdata : (cv ? c.wdata : 32'h0);
    endtask

    task automatic run_seq();
        xfer_t cur, dph;
        bit    cv = 1'b0, dv = 1'b0, rdy;
        int    w = 0, budget = 0;
        log_t  e;
        lg.delete();
        if (seq.size() > 0) begin cur = seq.pop_front(); cv = 1'b1; end
        drive(cv, cur, dv, dph);
        while (cv || dv) begin
            @(negedge clk);
            rdy = hready_s;
            if (dv) begin
                if (rdy) begin
                    e.rdata = hrdata_s; e.resp = hresp_s; e.waits = w;
                    lg.push_back(e);
                end else w++;
            end
            @(posedge clk);
            if (rdy) begin
                dv = cv && cur.trans[1]; dph = cur; w = 0;
                cv = 1'b0;
                if (seq.size() > 0) begin cur = seq.pop_front(); cv = 1'b1; end
            end
            #1;
            drive(cv, cur, dv, dph);
            budget++;
            if (budget > 200) begin
                checks++; errors++;
                $display("FAIL run_timeout: got %0d cycles expected at most 200", budget);
                seq.delete();
                cv = 1'b0; dv = 1'b0;
                drive(cv, cur, dv, dph);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #7;
        chk("rst_hready", {29'd0, hr_a}, 32'h7);
        chk("rst_hresp",  {29'd0, rs_a}, 32'h0);
        chk("rst_hrdata0", rd_a[0], 32'h0);
        chk("rst_hrdata1", rd_a[1], 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        model_on = 1'b1;
        @(posedge clk); #1;

        // zero-wait: write then forwarded read, byte/half lane writes
        sel = 0;
        push(2'b10, 3'd2, 1, 32'h0001_0004, 32'hDEADBEEF);
        push(2'b10, 3'd2, 0, 32'h0001_0004, 32'h0);
        push(2'b10, 3'd2, 1, 32'h0001_0008, 32'h11223344);
        push(2'b10, 3'd0, 1, 32'h0001_000A, 32'h00AA0000);
        push(2'b10, 3'd2, 0, 32'h0001_0008, 32'h0);
        push(2'b10, 3'd1, 1, 32'h0001_0008, 32'h00005566);
        push(2'b10, 3'd2, 0, 32'h0001_0008, 32'h0);
        run_seq();
        chk("a_len", lg.size(), 7);
        chk("a_wr_waits", lg[0].waits, 0);
        chk("a_fwd_rdata", lg[1].rdata, 32'hDEADBEEF);
        chk("a_fwd_waits", lg[1].waits, 0);
        chk("a_byte_rdata", lg[4].rdata, 32'h11AA3344);
        chk("a_half_rdata", lg[6].rdata, 32'h11AA5566);
        chk("a_model_word", mdl_word(0, 32'h0001_0008), 32'h11AA5566);

        // illegal transfers leave storage alone; no wrap into the region
        push(2'b10, 3'd2, 1, 32'h0001_0000, 32'hA5A5A5A5);
        push(2'b10, 3'd2, 1, 32'h0001_0010, 32'h01020304);
        push(2'b10, 3'd1, 0, 32'h0001_0001, 32'h0);
        push(2'b10, 3'd2, 1, 32'h0000_0010, 32'hFFFFFFFF);
        push(2'b10, 3'd2, 0, 32'h0001_0002, 32'h0);
        push(2'b10, 3'd2, 0, 32'h0001_0000, 32'h0);
        push(2'b10, 3'd2, 0, 32'h0001_0010, 32'h0);
        run_seq();
        chk("b_half_err_resp", lg[2].resp, 1);
        chk("b_half_err_waits", lg[2].waits, 1);
        chk("b_oor_err_resp", lg[3].resp, 1);
        chk("b_mis_err_resp", lg[4].resp, 1);
        chk("b_keep_10000", lg[5].rdata, 32'hA5A5A5A5);
        chk("b_keep_resp", lg[5].resp, 0);
        chk("b_nowrap_10010", lg[6].rdata, 32'h01020304);

        // BUSY/IDLE cycles write nothing
        push(2'b10, 3'd2, 1, 32'h0001_0014, 32'h77777777);
        for (int i = 0; i < 10; i++)
            push((i % 2 == 0) ? SCR1_HTRANS_BUSY : SCR1_HTRANS_IDLE, 3'd2, 1, 32'h0001_0014, 32'hFFFFFFFF);
        push(2'b10, 3'd2, 0, 32'h0001_0014, 32'h0);
        run_seq();
        chk("c_len", lg.size(), 2);
        chk("c_rdata", lg[1].rdata, 32'h77777777);

        // three wait states
        sel = 1;
        push(2'b10, 3'd2, 1, 32'h0001_0000, 32'h0BADF00D);
        push(2'b10, 3'd2, 0, 32'h0001_0000, 32'h0);
        push(2'b10, 3'd3, 0, 32'h0001_0000, 32'h0);
        push(2'b10, 3'd0, 1, 32'h0001_0001, 32'h0000EE00);
        push(2'b10, 3'd2, 0, 32'h0001_0000, 32'h0);
        run_seq();
        chk("d_wr_waits", lg[0].waits, 3);
        chk("d_rd_waits", lg[1].waits, 3);
        chk("d_rd_rdata", lg[1].rdata, 32'h0BADF00D);
        chk("d_rd_resp", lg[1].resp, 0);
        chk("d_size3_resp", lg[2].resp, 1);
        chk("d_byte_rdata", lg[4].rdata, 32'h0BADEE0D);

        // two wait states: reset in the middle of a write
        sel = 2;
        push(2'b10, 3'd2, 1, 32'h0001_000C, 32'hCAFEF00D);
        push(2'b10, 3'd2, 0, 32'h0001_000C, 32'h0);
        run_seq();
        chk("e_preset", lg[1].rdata, 32'hCAFEF00D);
        htrans_d = 2'b10; hsize_d = 3'd2; haddr_d = 32'h0001_000C; hwrite_d = 1'b1; hwdata_d = 32'h0;
        @(posedge clk); #1;
        htrans_d = 2'b00; hwrite_d = 1'b0; hwdata_d = 32'h12345678;
        @(posedge clk); #2;
        chk("f_wait_hready", {31'd0, hr_a[2]}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("f_rst_hready", {31'd0, hr_a[2]}, 32'h1);
        chk("f_rst_hresp",  {31'd0, rs_a[2]}, 32'h0);
        chk("f_rst_hrdata", rd_a[2], 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        hwdata_d = 32'h0;
        @(posedge clk); #1;
        push(2'b10, 3'd2, 0, 32'h0001_000C, 32'h0);
        run_seq();
        chk("f_unchanged", lg[0].rdata, 32'hCAFEF00D);
        chk("f_model_word", mdl_word(2, 32'h0001_000C), 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
